// File: rtl/mux_rr_stream.sv
// mux_rr_stream
//   N-channel, W-bit stream multiplexer with a registered output stage.
//   The grant comes either from round-robin arbitration (MODE=0) or from
//   fixed priority with the lowest index winning (MODE=1). With PKT=1 the
//   grant is held from the first beat of a packet until its last beat
//   transfers.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | grant chosen each cycle from in_valid
//   ST_LOCKED | grant held on lock_ch until a last=1 beat transfers
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_data    channel i data in bits [i*W +: W]
//   in_valid   per-channel beat valid
//   in_last    per-channel last-beat-of-packet flag
//   in_ready   per-channel accept, one-hot or zero
//   out_data   registered output data
//   out_valid  registered output valid
//   out_last   registered last flag
//   out_sel    channel index of the beat held in the output register
//   out_ready  consumer accept
//   busy       high while a packet holds the grant (PKT=1 only)
module mux_rr_stream #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int MODE = 0,
  parameter int PKT  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*W-1:0]       in_data,
  input  logic [N-1:0]         in_valid,
  input  logic [N-1:0]         in_last,
  output logic [N-1:0]         in_ready,
  output logic [W-1:0]         out_data,
  output logic                 out_valid,
  output logic                 out_last,
  output logic [$clog2(N)-1:0] out_sel,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam int SW = $clog2(N);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]    state;
  logic [SW-1:0] lock_ch;
  logic [SW-1:0] rr_ptr;
  logic [SW-1:0] search_base;
  logic [SW-1:0] idle_grant;
  logic          idle_valid;
  logic [SW-1:0] grant;
  logic          grant_valid;
  logic          ld;
  logic          xfer;
  logic [W-1:0]  sel_data;
  logic          sel_last;
  logic          end_of_grant;
  logic [SW-1:0] rr_next;

  // Returns {found, index} of the first set bit of v at or after base,
  // wrapping N-1 -> 0. Fixed priority is the same search from base 0.
  function automatic logic [SW:0] first_from(input logic [SW-1:0] base,
                                             input logic [N-1:0]  v);
    logic [SW:0]   res;
    logic [SW-1:0] idx;
    logic          found;
    int            pos;
    res   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      pos = int'(base) + k;
      if (pos >= N) pos = pos - N;
      idx = SW'(pos);
      if (!found && v[idx]) begin
        found = 1'b1;
        res   = {1'b1, idx};
      end
    end
    return res;
  endfunction

  always_comb begin
    search_base              = (MODE == 0) ? rr_ptr : '0;
    {idle_valid, idle_grant} = first_from(search_base, in_valid);

    if (state == ST_LOCKED) begin
      grant       = lock_ch;
      grant_valid = in_valid[lock_ch];
    end else begin
      grant       = idle_grant;
      grant_valid = idle_valid;
    end

    // The output register can take a new beat whenever it is empty or
    // being drained this same cycle, so streaming runs without bubbles.
    ld   = !out_valid | out_ready;
    xfer = ld & grant_valid;

    in_ready = '0;
    if (xfer) in_ready[grant] = 1'b1;

    // Only the granted lane is looked at, so junk on idle lanes never
    // reaches the output register.
    sel_data = in_data[int'(grant)*W +: W];
    sel_last = in_last[grant];

    end_of_grant = xfer & ((PKT == 0) | sel_last);
    rr_next      = (grant == SW'(N-1)) ? '0 : grant + SW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
    end else if (ld) begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_last  <= sel_last;
        out_sel   <= grant;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      lock_ch <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (xfer && (PKT != 0) && !sel_last) begin
            state   <= ST_LOCKED;
            lock_ch <= grant;
          end
        end
        ST_LOCKED: begin
          if (xfer && sel_last) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if ((MODE == 0) && end_of_grant) begin
      rr_ptr <= rr_next;
    end
  end

  assign busy = (state == ST_LOCKED);

endmodule

// File: tb/tb_mux_rr_stream.sv
// Bench for mux_rr_stream. Three instances (round-robin with packet lock,
// round-robin per beat, fixed priority with packet lock) share the input
// stimulus; 'cur' picks which one a test observes and checks.
module tb_mux_rr_stream;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]   in_valid = '0;
  logic [N-1:0]   in_last = '0;
  logic           out_ready = 1'b1;

  logic [N-1:0] rdy_a, rdy_b, rdy_c;
  logic [W-1:0] od_a, od_b, od_c;
  logic         ov_a, ov_b, ov_c, ol_a, ol_b, ol_c, bz_a, bz_b, bz_c;
  logic [1:0]   os_a, os_b, os_c;

  logic [N-1:0] c_in_ready;
  logic [W-1:0] c_out_data;
  logic         c_out_valid, c_out_last, c_busy;
  logic [1:0]   c_out_sel;

  int cur = 0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux_rr_stream #(.N(N), .W(W), .MODE(0), .PKT(1)) u_rr_pkt (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(rdy_a), .out_data(od_a), .out_valid(ov_a),
    .out_last(ol_a), .out_sel(os_a), .out_ready(out_ready), .busy(bz_a));

  mux_rr_stream #(.N(N), .W(W), .MODE(0), .PKT(0)) u_rr_beat (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(rdy_b), .out_data(od_b), .out_valid(ov_b),
    .out_last(ol_b), .out_sel(os_b), .out_ready(out_ready), .busy(bz_b));

  mux_rr_stream #(.N(N), .W(W), .MODE(1), .PKT(1)) u_fp (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(rdy_c), .out_data(od_c), .out_valid(ov_c),
    .out_last(ol_c), .out_sel(os_c), .out_ready(out_ready), .busy(bz_c));

  always_comb begin
    case (cur)
      1: begin
        c_in_ready = rdy_b; c_out_data = od_b; c_out_valid = ov_b;
        c_out_last = ol_b;  c_out_sel = os_b;  c_busy = bz_b;
      end
      2: begin
        c_in_ready = rdy_c; c_out_data = od_c; c_out_valid = ov_c;
        c_out_last = ol_c;  c_out_sel = os_c;  c_busy = bz_c;
      end
      default: begin
        c_in_ready = rdy_a; c_out_data = od_a; c_out_valid = ov_a;
        c_out_last = ol_a;  c_out_sel = os_a;  c_busy = bz_a;
      end
    endcase
  end

  // Reference model: arbitration picks the valid channel with the smallest
  // round-robin distance from the pointer (or the smallest index in fixed
  // priority); a held packet owns the link until its last beat goes.
  int         m_mode, m_pkt, m_ptr, m_lock_ch, m_os;
  bit         m_locked, m_ov, m_ol;
  logic [7:0] m_od;
  int         e_grant;
  bit         e_gv, e_ld, e_xfer;
  logic [N-1:0] e_ready;

  task automatic model_reset();
    m_ptr = 0; m_locked = 0; m_lock_ch = 0;
    m_ov = 0; m_ol = 0; m_od = 8'h00; m_os = 0;
  endtask

  task automatic model_eval();
    int best, d;
    best = N; e_grant = 0;
    if (m_locked) begin
      e_grant = m_lock_ch;
      best = in_valid[m_lock_ch] ? 0 : N;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (in_valid[i]) begin
          d = (m_mode == 1) ? i : (i - m_ptr + N) % N;
          if (d < best) begin best = d; e_grant = i; end
        end
      end
    end
    e_gv    = (best < N);
    e_ld    = !m_ov || out_ready;
    e_xfer  = e_ld && e_gv;
    e_ready = e_xfer ? N'(1 << e_grant) : '0;
  endtask

  task automatic model_edge();
    bit lst;
    lst = in_last[e_grant];
    if (e_xfer) begin
      m_ov = 1; m_od = in_data[e_grant*W +: W]; m_ol = lst; m_os = e_grant;
      if (m_pkt == 1) begin
        m_locked  = !lst;
        m_lock_ch = e_grant;
      end
      if (m_mode == 0 && (m_pkt == 0 || lst)) m_ptr = (e_grant + 1) % N;
    end else if (e_ld) begin
      m_ov = 0;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    cur = 0;
    do_reset();
    out_ready = 1'b0;
    in_valid = 4'b0100; in_last = 4'b0000; in_data[16 +: 8] = 8'h5C;
    cyc();
    checks++; if (c_out_valid !== 1'b1) begin failures++; $display("FAIL reset_pre_valid: got %b expected 1", c_out_valid); end
    checks++; if (c_busy !== 1'b1) begin failures++; $display("FAIL reset_pre_busy: got %b expected 1", c_busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (c_out_valid !== 1'b0) begin failures++; $display("FAIL reset_async_valid: got %b expected 0", c_out_valid); end
    checks++; if (c_out_sel !== 2'd0) begin failures++; $display("FAIL reset_async_sel: got %0d expected 0", c_out_sel); end
    checks++; if (c_busy !== 1'b0) begin failures++; $display("FAIL reset_async_busy: got %b expected 0", c_busy); end
    checks++; if (c_out_data !== 8'h00) begin failures++; $display("FAIL reset_async_data: got %h expected 00", c_out_data); end
    in_valid = '0; out_ready = 1'b1;
    #1;
    checks++; if (c_in_ready !== 4'b0000) begin failures++; $display("FAIL reset_idle_ready: got %b expected 0000", c_in_ready); end
    rst_n = 1'b1;
    cyc();
    checks++; if (c_in_ready !== 4'b0000) begin failures++; $display("FAIL idle_ready: got %b expected 0000", c_in_ready); end
    checks++; if (c_out_valid !== 1'b0) begin failures++; $display("FAIL idle_valid: got %b expected 0", c_out_valid); end
  endtask

  task automatic test_rr_fairness();
    cur = 1;
    do_reset();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'hA0 + 8'(i);
    in_valid = 4'b1111; in_last = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (c_in_ready !== 4'(1 << (k % 4))) begin failures++; $display("FAIL rr_ready[%0d]: got %b expected %b", k, c_in_ready, 4'(1 << (k % 4))); end
      cyc();
      checks++; if (c_out_valid !== 1'b1 || c_out_data !== 8'hA0 + 8'(k % 4)) begin failures++; $display("FAIL rr_data[%0d]: got v=%b %h expected v=1 %h", k, c_out_valid, c_out_data, 8'hA0 + 8'(k % 4)); end
      checks++; if (c_out_sel !== 2'(k % 4)) begin failures++; $display("FAIL rr_sel[%0d]: got %0d expected %0d", k, c_out_sel, k % 4); end
    end
  endtask

  task automatic test_pkt_lock();
    cur = 0;
    do_reset();
    out_ready = 1'b1;
    in_valid = 4'b0010; in_last = 4'b0010; in_data[8 +: 8] = 8'h11;
    cyc();
    in_valid = 4'b0101; in_last = 4'b0001; in_data[0 +: 8] = 8'h01;
    for (int b = 0; b < 3; b++) begin
      in_data[16 +: 8] = 8'h21 + 8'(b);
      in_last[2] = (b == 2);
      #1;
      checks++; if (c_in_ready !== 4'b0100) begin failures++; $display("FAIL lock_ready[%0d]: got %b expected 0100", b, c_in_ready); end
      checks++; if (c_busy !== (b != 0)) begin failures++; $display("FAIL lock_busy_pre[%0d]: got %b expected %b", b, c_busy, b != 0); end
      cyc();
      checks++; if (c_out_sel !== 2'd2 || c_out_data !== 8'h21 + 8'(b)) begin failures++; $display("FAIL lock_out[%0d]: got sel=%0d %h expected sel=2 %h", b, c_out_sel, c_out_data, 8'h21 + 8'(b)); end
    end
    checks++; if (c_busy !== 1'b0) begin failures++; $display("FAIL lock_busy_end: got %b expected 0", c_busy); end
    in_valid = 4'b0001;
    #1;
    checks++; if (c_in_ready !== 4'b0001) begin failures++; $display("FAIL lock_next_ready: got %b expected 0001", c_in_ready); end
    cyc();
    checks++; if (c_out_sel !== 2'd0 || c_out_data !== 8'h01) begin failures++; $display("FAIL lock_next_out: got sel=%0d %h expected sel=0 01", c_out_sel, c_out_data); end
  endtask

  task automatic test_backpressure();
    int cnt, exp_next, consumed;
    cur = 1;
    do_reset();
    cnt = 0; exp_next = 0; consumed = 0;
    in_valid = 4'b0010; in_last = 4'b0010; out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_data[8 +: 8] = 8'h40 + 8'(cnt);
      #1;
      checks++; if (c_in_ready !== ((k == 0) ? 4'b0010 : 4'b0000)) begin failures++; $display("FAIL bp_ready[%0d]: got %b expected %b", k, c_in_ready, (k == 0) ? 4'b0010 : 4'b0000); end
      if (c_in_ready[1]) cnt++;
      cyc();
      checks++; if (c_out_valid !== 1'b1 || c_out_data !== 8'h40) begin failures++; $display("FAIL bp_hold[%0d]: got v=%b %h expected v=1 40", k, c_out_valid, c_out_data); end
    end
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_data[8 +: 8] = 8'h40 + 8'(cnt);
      #1;
      checks++; if (c_in_ready !== 4'b0010) begin failures++; $display("FAIL bp_stream_ready[%0d]: got %b expected 0010", k, c_in_ready); end
      if (c_out_valid) begin
        checks++; if (c_out_data !== 8'h40 + 8'(exp_next)) begin failures++; $display("FAIL bp_order[%0d]: got %h expected %h", k, c_out_data, 8'h40 + 8'(exp_next)); end
        exp_next++; consumed++;
      end
      if (c_in_ready[1]) cnt++;
      cyc();
    end
    checks++; if (consumed !== 6) begin failures++; $display("FAIL bp_count: got %0d expected 6", consumed); end
  endtask

  task automatic test_fixed_priority();
    cur = 2;
    do_reset();
    out_ready = 1'b1;
    in_valid = 4'b1010; in_last = 4'b1010;
    in_data[8 +: 8] = 8'h11; in_data[24 +: 8] = 8'h33;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (c_in_ready !== 4'b0010) begin failures++; $display("FAIL fp_ready[%0d]: got %b expected 0010", k, c_in_ready); end
      cyc();
      checks++; if (c_out_sel !== 2'd1 || c_out_data !== 8'h11) begin failures++; $display("FAIL fp_out[%0d]: got sel=%0d %h expected sel=1 11", k, c_out_sel, c_out_data); end
    end
    in_valid = 4'b1000;
    #1;
    checks++; if (c_in_ready !== 4'b1000) begin failures++; $display("FAIL fp_drop_ready: got %b expected 1000", c_in_ready); end
    cyc();
    checks++; if (c_out_sel !== 2'd3 || c_out_data !== 8'h33) begin failures++; $display("FAIL fp_drop_out: got sel=%0d %h expected sel=3 33", c_out_sel, c_out_data); end
  endtask

  task automatic test_locked_stall();
    cur = 0;
    do_reset();
    out_ready = 1'b1;
    in_valid = 4'b0100; in_last = 4'b0100; in_data[16 +: 8] = 8'h2A;
    cyc();
    in_valid = 4'b1001; in_last = 4'b0001;
    in_data[0 +: 8] = 8'h0A; in_data[24 +: 8] = 8'h3A;
    #1;
    checks++; if (c_in_ready !== 4'b1000) begin failures++; $display("FAIL stall_lock_ready: got %b expected 1000", c_in_ready); end
    cyc();
    checks++; if (c_busy !== 1'b1 || c_out_sel !== 2'd3) begin failures++; $display("FAIL stall_locked: got busy=%b sel=%0d expected busy=1 sel=3", c_busy, c_out_sel); end
    in_valid = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (c_in_ready !== 4'b0000) begin failures++; $display("FAIL stall_ready[%0d]: got %b expected 0000", k, c_in_ready); end
      cyc();
      checks++; if (c_out_valid !== 1'b0 || c_busy !== 1'b1 || c_out_sel !== 2'd3) begin failures++; $display("FAIL stall_state[%0d]: got v=%b busy=%b sel=%0d expected v=0 busy=1 sel=3", k, c_out_valid, c_busy, c_out_sel); end
    end
    in_valid = 4'b1001; in_last = 4'b1001; in_data[24 +: 8] = 8'h3B;
    #1;
    checks++; if (c_in_ready !== 4'b1000) begin failures++; $display("FAIL stall_last_ready: got %b expected 1000", c_in_ready); end
    cyc();
    checks++; if (c_busy !== 1'b0 || c_out_last !== 1'b1 || c_out_data !== 8'h3B) begin failures++; $display("FAIL stall_last_out: got busy=%b last=%b %h expected busy=0 last=1 3B", c_busy, c_out_last, c_out_data); end
    #1;
    checks++; if (c_in_ready !== 4'b0001) begin failures++; $display("FAIL stall_wrap_ready: got %b expected 0001", c_in_ready); end
    cyc();
    checks++; if (c_out_sel !== 2'd0 || c_out_data !== 8'h0A) begin failures++; $display("FAIL stall_wrap_out: got sel=%0d %h expected sel=0 0A", c_out_sel, c_out_data); end
  endtask

  task automatic test_random(input int which);
    cur = which;
    m_mode = (which == 2) ? 1 : 0;
    m_pkt  = (which == 1) ? 0 : 1;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        in_valid[i] = ($urandom_range(9) < 6);
        in_last[i]  = ($urandom_range(2) == 0);
        in_data[i*W +: W] = 8'($urandom);
      end
      out_ready = ($urandom_range(3) != 0);
      #1;
      model_eval();
      checks++; if (c_in_ready !== e_ready) begin failures++; $display("FAIL rand%0d_ready c%0d: got %b expected %b", which, c, c_in_ready, e_ready); end
      @(posedge clk);
      model_edge();
      #1;
      checks++;
      if (c_out_valid !== m_ov || c_out_data !== m_od || c_out_last !== m_ol ||
          c_out_sel !== 2'(m_os) || c_busy !== m_locked) begin
        failures++;
        $display("FAIL rand%0d_out c%0d: got v=%b d=%h l=%b s=%0d b=%b expected v=%b d=%h l=%b s=%0d b=%b",
                 which, c, c_out_valid, c_out_data, c_out_last, c_out_sel, c_busy,
                 m_ov, m_od, m_ol, m_os, m_locked);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rr_fairness();
    test_pkt_lock();
    test_backpressure();
    test_fixed_priority();
    test_locked_stall();
    test_random(0);
    test_random(1);
    test_random(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_rr_stream.md
Name: mux_rr_stream

Overview:
- Parametrised N-channel, W-bit registered stream multiplexer; the successor to the team's single-bit 2:1 gate mux.
- Arbitration replaces the external select: round-robin or fixed priority, with optional packet locking.
- Valid/ready handshake on every port, plus one output register stage.
- Merges several producer streams onto one shared consumer link.

Parameters:
N, 4, number of input channels (N >= 2)
W, 8, data width per channel
MODE, 0, 0 = round-robin arbitration, 1 = fixed priority (lowest index wins)
PKT, 1, 1 = hold grant until a beat with last=1 transfers; 0 = re-arbitrate every beat

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_data  input  N*W  channel i data in bits [i*W +: W]
in_valid  input  N  channel i beat valid
in_last  input  N  channel i beat is last of packet
in_ready  output  N  channel i beat accepted this cycle when in_valid[i] & in_ready[i]
out_data  output  W  registered output data
out_valid  output  1  registered output valid
out_last  output  1  registered last flag
out_sel  output  clog2(N)  channel index of the beat currently in the output register
out_ready  input  1  consumer accepts when out_valid & out_ready
busy  output  1  1 while a packet is locked (PKT=1 only; always 0 when PKT=0)

Behaviour:
- Reset (async, rst_n=0) clears all state regardless of clk: out_valid=0, out_data=0, out_last=0, out_sel=0, busy=0, rr pointer=0, FSM=IDLE.
- Load enable: ld = !out_valid | out_ready. This keeps throughput at 1 beat/cycle with no bubble under continuous traffic.
- in_ready[i] = ld & (i == grant) & grant_valid. All other in_ready bits are 0, so in_ready is always one-hot or zero.
- Latency: an accepted beat appears on out_* at the next rising edge.
- Output register holds its value while out_valid=1 and out_ready=0.
- FSM states:
  - IDLE: grant is computed combinationally from in_valid.
    - MODE=0: first valid channel at or after the rr pointer, wrapping N-1 -> 0.
    - MODE=1: lowest valid index.
    - grant_valid = |in_valid.
  - LOCKED: grant = the locked channel; grant_valid = in_valid[locked].
- IDLE -> LOCKED: PKT=1 and the accepted beat has last=0. Store the channel and set busy=1.
- LOCKED -> IDLE: the locked channel transfers a beat with last=1. busy=0 on the following cycle.
- While LOCKED, other channels get in_ready=0 even if the locked channel drops valid. There is no timeout.
- A single-beat packet (last=1 on the first beat) stays in IDLE.
- RR pointer, MODE=0 only; it stays at 0 in MODE=1:
  - updates to (grant+1) mod N on each end-of-grant transfer;
  - end-of-grant is a last=1 beat when PKT=1, or any beat when PKT=0;
  - no transfer means no update.
- Simultaneous events: in the same cycle, the output consumer drains and a new beat loads; the new beat is stored and out_valid stays 1.
- No valid inputs and out_ready=1: out_valid falls to 0. out_data and out_sel hold their last values.
- Reset asserted mid-packet: the lock, pointer and pending output beat are discarded. Producers must restart the packet.
- in_data/in_last are sampled only for the granted channel. X on non-granted channels must not propagate.

Test Plan:
- Reset then idle: rst_n=0 mid-run with out_valid=1 -> out_valid=0, out_sel=0 and busy=0 asynchronously; in_ready=0 while all in_valid=0.
- Round-robin fairness: N=4, MODE=0, PKT=0, all in_valid=1, out_ready=1, in_last=1, data ch_i=8'hA0+i -> out_data sequence A0,A1,A2,A3,A0, one per cycle; out_sel 0,1,2,3,0.
- Packet lock: PKT=1, ch2 sends 3 beats (last on 3rd), ch0 valid throughout -> out_sel=2 for 3 consecutive beats; busy=1 from 2nd to 3rd cycle; ch0 served next; pointer=3.
- Backpressure: out_ready=0 for 5 cycles with ch1 valid -> out_data stable, in_ready[1]=0 after first load; ready restored -> no beat lost or duplicated.
- Fixed priority: MODE=1, ch1 and ch3 valid continuously -> only ch1 served; ch3 served the cycle after ch1 drops valid.
- Locked stall and wrap: PKT=1, ch3 locks then drops valid 4 cycles while ch0 valid -> no transfer, in_ready[0]=0; ch3 sends last -> ch0 granted next (pointer wraps 3->0).
